// File: rtl/t07_mmio_pkg.sv
// Shared types and constants for the team_07 MMIO router and its ESP32 receive FIFO.
package t07_mmio_pkg;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_STORE = 2'b01,
    RW_LOAD  = 2'b10,
    RW_FETCH = 2'b11
  } rw_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_WB_WAIT,
    S_TFT_WAIT,
    S_RESP
  } state_e;

  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  // Word offsets inside the RX window, measured from IMEM_TOP.
  localparam int unsigned RX_OFF_DATA   = 0;
  localparam int unsigned RX_OFF_STATUS = 4;

  function automatic logic rw_is_read(input rw_e rw);
    return (rw == RW_LOAD) || (rw == RW_FETCH);
  endfunction

endpackage

// File: rtl/t07_rx_fifo.sv
// ESP32 receive FIFO: drops words when full (sticky overflow), push+pop while full is allowed.
module t07_rx_fifo #(
  parameter int DATA_W   = 32,
  parameter int RX_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        push_i,
  input  logic [DATA_W-1:0]           push_data_i,
  input  logic                        pop_i,
  input  logic                        ovf_clr_i,
  output logic [DATA_W-1:0]           head_o,
  output logic                        empty_o,
  output logic [$clog2(RX_DEPTH):0]   count_o,
  output logic                        overflow_o
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              full, do_push, do_pop;

  assign full       = (cnt_q == CNT_W'(RX_DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full || do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    if (ovf_clr_i) ovf_d = 1'b0;
    // A word lost in the same cycle as a status read must stay visible.
    if (push_i && full && !do_pop) ovf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers and count is enough to empty it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/t07_mmio_router.sv
// Sequential CPU MMIO router: one request at a time, routed to Wishbone, the ESP32 RX FIFO or the TFT writer.
module t07_mmio_router
  import t07_mmio_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                RX_DEPTH  = 8,
  parameter int                IMEM_TOP  = 1024,
  parameter int                RX_TOP    = 1056,
  parameter int                DMEM_TOP  = 1792,
  parameter int                TFT_TOP   = 2047,
  parameter logic [DATA_W-25:0] WB_PREFIX = 8'h33
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid_i,
  input  logic [1:0]        req_rw_i,
  input  logic [DATA_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              busy_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              wb_read_o,
  output logic              wb_write_o,
  output logic [DATA_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  input  logic [DATA_W-1:0] wb_rdata_i,
  input  logic              wb_ack_i,
  output logic              tft_write_o,
  output logic [DATA_W-1:0] tft_addr_o,
  output logic [DATA_W-1:0] tft_data_o,
  input  logic              tft_ack_i,
  input  logic [DATA_W-1:0] spi_data_i,
  input  logic              spi_valid_i
);

  localparam int                CNT_W      = $clog2(RX_DEPTH) + 1;
  localparam logic [DATA_W-1:0] IMEM_TOP_W = DATA_W'(IMEM_TOP);
  localparam logic [DATA_W-1:0] RX_TOP_W   = DATA_W'(RX_TOP);
  localparam logic [DATA_W-1:0] DMEM_TOP_W = DATA_W'(DMEM_TOP);
  localparam logic [DATA_W-1:0] TFT_TOP_W  = DATA_W'(TFT_TOP);
  localparam logic [DATA_W-1:0] BAD_W      = DATA_W'(DEADBEEF);
  localparam logic [DATA_W-1:0] WORD_MASK  = ~(DATA_W'(3));

  state_e            state_q, state_d;
  rw_e               rw_q, rw_d;
  logic              busy_q, busy_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic              wb_read_q, wb_read_d, wb_write_q, wb_write_d, tft_write_q, tft_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d, wb_addr_q, wb_addr_d, wb_wdata_q, wb_wdata_d;
  logic [DATA_W-1:0] tft_addr_q, tft_addr_d, tft_data_q, tft_data_d;

  logic              fifo_pop, fifo_ovf_clr, fifo_empty, fifo_ovf;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  logic              req_rd, in_wb, in_rx, in_tft;
  logic [DATA_W-1:0] rx_off, rx_status;

  t07_rx_fifo #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .push_i     (spi_valid_i),
    .push_data_i(spi_data_i),
    .pop_i      (fifo_pop),
    .ovf_clr_i  (fifo_ovf_clr),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .overflow_o (fifo_ovf)
  );

  assign req_rd = rw_is_read(rw_e'(req_rw_i));
  assign in_wb  = (req_addr_i <= IMEM_TOP_W) ||
                  ((req_addr_i > RX_TOP_W) && (req_addr_i <= DMEM_TOP_W));
  assign in_rx  = (req_addr_i > IMEM_TOP_W) && (req_addr_i <= RX_TOP_W);
  assign in_tft = (req_addr_i > DMEM_TOP_W) && (req_addr_i <= TFT_TOP_W);
  // Word-granular RX offset, so byte addresses 1025..1027 all hit the data word.
  assign rx_off = (req_addr_i - IMEM_TOP_W) & WORD_MASK;

  always_comb begin
    rx_status              = '0;
    rx_status[DATA_W-1]    = fifo_ovf;
    rx_status[CNT_W-1:0]   = fifo_count;
  end

  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    rsp_rdata_d  = rsp_rdata_q;
    wb_addr_d    = wb_addr_q;
    wb_wdata_d   = wb_wdata_q;
    tft_addr_d   = tft_addr_q;
    tft_data_d   = tft_data_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    wb_read_d    = 1'b0;
    wb_write_d   = 1'b0;
    tft_write_d  = 1'b0;
    fifo_pop     = 1'b0;
    fifo_ovf_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && (req_rw_i != RW_IDLE)) begin
          rw_d = rw_e'(req_rw_i);
          if (in_wb) begin
            state_d    = S_WB_REQ;
            wb_addr_d  = {WB_PREFIX, req_addr_i[23:0]};
            wb_wdata_d = req_wdata_i;
            wb_read_d  = req_rd;
            wb_write_d = !req_rd;
          end else if (in_rx && req_rd) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            if (rx_off == DATA_W'(RX_OFF_DATA)) begin
              fifo_pop    = !fifo_empty;
              rsp_rdata_d = fifo_empty ? BAD_W : fifo_head;
            end else if (rx_off == DATA_W'(RX_OFF_STATUS)) begin
              fifo_ovf_clr = 1'b1;
              rsp_rdata_d  = rx_status;
            end else begin
              rsp_rdata_d = '0;
            end
          end else if (in_tft && !req_rd) begin
            state_d     = S_TFT_WAIT;
            tft_write_d = 1'b1;
            tft_addr_d  = req_addr_i;
            tft_data_d  = req_wdata_i;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = BAD_W;
          end
        end
      end
      S_WB_REQ: state_d = S_WB_WAIT;
      S_WB_WAIT: begin
        if (wb_ack_i) begin
          if (rw_is_read(rw_q)) rsp_rdata_d = wb_rdata_i;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      S_TFT_WAIT: begin
        tft_write_d = !tft_ack_i;
        if (tft_ack_i) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      rw_q        <= RW_IDLE;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= BAD_W;
      wb_read_q   <= 1'b0;
      wb_write_q  <= 1'b0;
      wb_addr_q   <= BAD_W;
      wb_wdata_q  <= BAD_W;
      tft_write_q <= 1'b0;
      tft_addr_q  <= BAD_W;
      tft_data_q  <= BAD_W;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wb_read_q   <= wb_read_d;
      wb_write_q  <= wb_write_d;
      wb_addr_q   <= wb_addr_d;
      wb_wdata_q  <= wb_wdata_d;
      tft_write_q <= tft_write_d;
      tft_addr_q  <= tft_addr_d;
      tft_data_q  <= tft_data_d;
    end
  end

  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign wb_read_o   = wb_read_q;
  assign wb_write_o  = wb_write_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_wdata_o  = wb_wdata_q;
  assign tft_write_o = tft_write_q;
  assign tft_addr_o  = tft_addr_q;
  assign tft_data_o  = tft_data_q;

endmodule

// File: tb/tb_t07_mmio_router.sv
// Scoreboard bench for t07_mmio_router: driver pushes expected responses, a monitor pops and compares.
module tb_t07_mmio_router;

  localparam int RX_DEPTH = 8;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid_i;
  logic [1:0]  req_rw_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        busy_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        wb_read_o, wb_write_o, wb_ack_i;
  logic [31:0] wb_addr_o, wb_wdata_o, wb_rdata_i;
  logic        tft_write_o, tft_ack_i;
  logic [31:0] tft_addr_o, tft_data_o;
  logic [31:0] spi_data_i;
  logic        spi_valid_i;

  t07_mmio_router #(.DATA_W(32), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid_i(req_valid_i), .req_rw_i(req_rw_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .busy_o(busy_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wb_read_o(wb_read_o), .wb_write_o(wb_write_o), .wb_addr_o(wb_addr_o), .wb_wdata_o(wb_wdata_o),
    .wb_rdata_i(wb_rdata_i), .wb_ack_i(wb_ack_i),
    .tft_write_o(tft_write_o), .tft_addr_o(tft_addr_o), .tft_data_o(tft_data_o), .tft_ack_i(tft_ack_i),
    .spi_data_i(spi_data_i), .spi_valid_i(spi_valid_i)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] rdata;
  } exp_t;

  int n_checks = 0, n_err = 0;
  int cyc = 0, rsp_cnt = 0, last_rsp_cyc = 0;
  int wb_rd_hi = 0, wb_wr_hi = 0, tft_hi = 0;
  int wb_delay = 1, tft_delay = 1;
  logic [31:0] wb_last_addr, wb_last_wdata, tft_last_addr, tft_last_data;

  exp_t        sb[$];
  logic [31:0] rx_q[$];
  logic        rx_ovf = 1'b0;
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] wb_mem [logic [31:0]];
  logic [31:0] bnd [9] = '{32'd0, 32'd1024, 32'd1025, 32'd1056, 32'd1057,
                           32'd1792, 32'd1793, 32'd2047, 32'd2048};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Contents an untouched Wishbone word is assumed to hold.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (wb_read_o)   wb_rd_hi++;
    if (wb_write_o)  wb_wr_hi++;
    if (tft_write_o) tft_hi++;
  end

  // Monitor: every response cycle is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid_o) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL rsp_unexpected: got response rdata %h err %b, expected none", rsp_rdata_o, rsp_err_o);
        end else begin
          e = sb.pop_front();
          check("rsp_err", 32'(rsp_err_o), 32'(e.err));
          if (e.chk) check("rsp_rdata", rsp_rdata_o, e.rdata);
        end
      end
    end
  end

  // Wishbone slave: memory keyed by the Wishbone address it actually sees.
  initial begin
    int d;
    logic rd;
    logic [31:0] a;
    wb_ack_i = 1'b0;
    wb_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (nrst && (wb_read_o || wb_write_o)) begin
        a = wb_addr_o;
        rd = wb_read_o;
        d = wb_delay;
        wb_last_addr = a;
        wb_last_wdata = wb_wdata_o;
        if (!rd) wb_mem[a] = wb_wdata_o;
        repeat (d) @(negedge clk);
        wb_rdata_i = rd ? (wb_mem.exists(a) ? wb_mem[a] : dflt(a)) : $urandom;
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_rdata_i = $urandom;
      end
    end
  end

  // TFT slave: acknowledges in the tft_delay-th cycle of the write request.
  initial begin
    int d;
    tft_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst && tft_write_o) begin
        tft_last_addr = tft_addr_o;
        tft_last_data = tft_data_o;
        d = tft_delay;
        repeat (d - 1) @(negedge clk);
        tft_ack_i = 1'b1;
        @(negedge clk);
        tft_ack_i = 1'b0;
      end
    end
  end

  task automatic push_word(input logic [31:0] d);
    @(negedge clk);
    spi_valid_i = 1'b1;
    spi_data_i = d;
    if (rx_q.size() < RX_DEPTH) rx_q.push_back(d);
    else rx_ovf = 1'b1;
    @(negedge clk);
    spi_valid_i = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic with_push, input logic [31:0] pdata);
    exp_t e;
    logic rd;
    int kind, exp_lat, rd0, wr0, tft0, rsp0, acc, w;
    logic [31:0] off;
    rd = rw[1];
    e.err = 1'b0;
    e.chk = 1'b0;
    e.rdata = '0;
    if (addr <= 1024 || (addr > 1056 && addr <= 1792)) begin
      kind = 0;
      exp_lat = 2 + wb_delay;
      if (rd) begin
        e.chk = 1'b1;
        e.rdata = model_mem.exists(addr) ? model_mem[addr] : dflt({8'h33, addr[23:0]});
      end else begin
        model_mem[addr] = wdata;
      end
    end else if (addr > 1024 && addr <= 1056 && rd) begin
      kind = 1;
      exp_lat = 1;
      e.chk = 1'b1;
      off = (addr - 32'd1024) & ~32'd3;
      if (off == 0) begin
        e.rdata = (rx_q.size() > 0) ? rx_q.pop_front() : BAD;
      end else if (off == 4) begin
        e.rdata = {rx_ovf, 31'(rx_q.size())};
        rx_ovf = 1'b0;
      end
    end else if (addr > 1792 && addr <= 2047 && !rd) begin
      kind = 2;
      exp_lat = 1 + tft_delay;
    end else begin
      kind = 3;
      exp_lat = 1;
      e.err = 1'b1;
      e.chk = 1'b1;
      e.rdata = BAD;
    end
    if (with_push) begin
      if (rx_q.size() < RX_DEPTH) rx_q.push_back(pdata);
      else rx_ovf = 1'b1;
    end
    sb.push_back(e);
    rd0 = wb_rd_hi; wr0 = wb_wr_hi; tft0 = tft_hi; rsp0 = rsp_cnt;
    @(negedge clk);
    req_valid_i = 1'b1; req_rw_i = rw; req_addr_i = addr; req_wdata_i = wdata;
    spi_valid_i = with_push; spi_data_i = pdata;
    acc = cyc;
    @(negedge clk);
    req_valid_i = 1'b0; req_rw_i = 2'b00; spi_valid_i = 1'b0;
    w = 0;
    while (busy_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("busy_timeout", 32'(busy_o), 32'd0);
    check("rsp_count", 32'(rsp_cnt - rsp0), 32'd1);
    check("latency", 32'(last_rsp_cyc - acc), 32'(exp_lat));
    check("wb_read_pulses", 32'(wb_rd_hi - rd0), (kind == 0 && rd) ? 32'd1 : 32'd0);
    check("wb_write_pulses", 32'(wb_wr_hi - wr0), (kind == 0 && !rd) ? 32'd1 : 32'd0);
    check("tft_write_cycles", 32'(tft_hi - tft0), (kind == 2) ? 32'(tft_delay) : 32'd0);
    if (kind == 0) begin
      check("wb_addr", wb_last_addr, {8'h33, addr[23:0]});
      if (!rd) check("wb_wdata", wb_last_wdata, wdata);
    end
    if (kind == 2) begin
      check("tft_addr", tft_last_addr, addr);
      check("tft_data", tft_last_data, wdata);
    end
  endtask

  initial begin
    logic [31:0] a;
    int rsp0;
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its summary, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int rsp0;
    nrst = 1'b0;
    req_valid_i = 1'b0; req_rw_i = 2'b00; req_addr_i = '0; req_wdata_i = '0;
    spi_valid_i = 1'b0; spi_data_i = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    check("rst_wb_read", 32'(wb_read_o), 32'd0);
    check("rst_wb_write", 32'(wb_write_o), 32'd0);
    check("rst_tft_write", 32'(tft_write_o), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_o, BAD);
    check("rst_wb_addr", wb_addr_o, BAD);
    check("rst_wb_wdata", wb_wdata_o, BAD);
    check("rst_tft_addr", tft_addr_o, BAD);
    check("rst_tft_data", tft_data_o, BAD);
    nrst = 1'b1;

    // Fetch and store through Wishbone.
    model_mem[32'h100] = 32'h00500093;
    wb_mem[32'h33000100] = 32'h00500093;
    wb_delay = 2;
    do_req(2'b11, 32'h100, 32'h0, 1'b0, 32'h0);
    wb_delay = 1;
    do_req(2'b01, 32'd1100, 32'hCAFEF00D, 1'b0, 32'h0);
    do_req(2'b10, 32'd1100, 32'h0, 1'b0, 32'h0);

    // RX FIFO: status, pops, empty pop.
    push_word(32'd1); push_word(32'd2); push_word(32'd3);
    do_req(2'b10, 32'd1028, 32'h0, 1'b0, 32'h0);
    repeat (4) do_req(2'b10, 32'd1025, 32'h0, 1'b0, 32'h0);

    // Overflow, clear-on-read, push+pop while full.
    for (int i = 0; i < RX_DEPTH + 1; i++) push_word(32'd10 + 32'(i));
    do_req(2'b10, 32'd1028, 32'h0, 1'b0, 32'h0);
    do_req(2'b10, 32'd1028, 32'h0, 1'b0, 32'h0);
    do_req(2'b10, 32'd1025, 32'h0, 1'b1, 32'd99);
    do_req(2'b10, 32'd1028, 32'h0, 1'b0, 32'h0);

    // TFT store and error cases.
    tft_delay = 5;
    do_req(2'b01, 32'd1800, 32'h1234ABCD, 1'b0, 32'h0);
    tft_delay = 1;
    do_req(2'b10, 32'd4096, 32'h0, 1'b0, 32'h0);
    do_req(2'b01, 32'd1025, 32'h5555AAAA, 1'b0, 32'h0);
    do_req(2'b10, 32'd1900, 32'h0, 1'b0, 32'h0);

    // rw=00 with valid is not a request.
    @(negedge clk);
    req_valid_i = 1'b1; req_rw_i = 2'b00; req_addr_i = 32'h100;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("idle_rw_ignored", 32'(busy_o), 32'd0);

    // Reset while waiting for the Wishbone ack.
    push_word(32'hAAAA0001); push_word(32'hAAAA0002);
    wb_delay = 10;
    rsp0 = rsp_cnt;
    @(negedge clk);
    req_valid_i = 1'b1; req_rw_i = 2'b11; req_addr_i = 32'h200;
    @(negedge clk);
    req_valid_i = 1'b0; req_rw_i = 2'b00;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("abort_wb_read", 32'(wb_read_o), 32'd0);
    check("abort_wb_write", 32'(wb_write_o), 32'd0);
    check("abort_tft_write", 32'(tft_write_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
    rx_q.delete();
    rx_ovf = 1'b0;
    repeat (15) @(negedge clk);
    nrst = 1'b1;
    check("abort_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
    wb_delay = 1;
    do_req(2'b10, 32'd1028, 32'h0, 1'b0, 32'h0);
    do_req(2'b11, 32'h100, 32'h0, 1'b0, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      wb_delay = $urandom_range(1, 4);
      tft_delay = $urandom_range(1, 4);
      repeat ($urandom_range(0, 2)) push_word($urandom);
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 1024);
        1: a = ($urandom_range(0, 2) == 0) ? 32'd1028 :
               (($urandom_range(0, 1) == 0) ? 32'd1025 : 32'd1025 + $urandom_range(0, 31));
        2: a = $urandom_range(1057, 1792);
        3: a = $urandom_range(1793, 2047);
        4: a = 32'd2048 + $urandom_range(0, 100000);
        default: a = bnd[$urandom_range(0, 8)];
      endcase
      do_req(2'($urandom_range(1, 3)), a, $urandom, ($urandom_range(0, 3) == 0), $urandom);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
